// File: rtl/exec_unit_p_pkg.sv
// -----------------------------------------------------------------------------
// exec_unit_p_pkg
//   Shared definitions for the NoobsCpu execute unit: opcode encoding,
//   status-flag layout and the control FSM state encoding.
//   Opcodes 0-B keep their legacy values; C-F are the carry-chain / compare /
//   multiply extensions.
// -----------------------------------------------------------------------------
package exec_unit_p_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_ADD    = 4'h1,
      OP_SUB    = 4'h2,
      OP_OR     = 4'h3,
      OP_AND    = 4'h4,
      OP_XOR    = 4'h5,
      OP_MEM_RD = 4'h6,
      OP_MEM_WR = 4'h7,
      OP_JMP    = 4'h8,
      OP_CALL   = 4'h9,
      OP_RET    = 4'hA,
      OP_IDLE   = 4'hB,
      OP_ADC    = 4'hC,
      OP_SBB    = 4'hD,
      OP_CMP    = 4'hE,
      OP_MUL    = 4'hF
   } op_e;

   // Flag register layout as seen on the flags port: {Z,N,C,V}.
   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_MEM  = 2'd2
   } state_e;

   function automatic logic is_mem_op(input op_e o);
      return (o == OP_MEM_RD) || (o == OP_MEM_WR);
   endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// -----------------------------------------------------------------------------
// exec_mul_iter
//   Iterative shift-add multiplier, one multiplier bit per clock.
//   i_start loads the operands; DATA_W iterations follow. o_done is high in the
//   cycle of the last iteration and o_prod then carries the full product, so
//   the caller can register it on that same edge.
// Ports
//   clk, reset_        clock, async active-low reset (aborts a multiply)
//   i_start            load i_a / i_b and begin
//   i_a, i_b           multiplicand / multiplier
//   o_done             last iteration in progress this cycle
//   o_prod             2*DATA_W product (valid with o_done)
// -----------------------------------------------------------------------------
module exec_mul_iter #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_,
   input  logic                  i_start,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic                  o_done,
   output logic [2*DATA_W-1:0]   o_prod
);

   localparam int              CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic                 r_act;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*DATA_W-1:0]  r_acc;
   logic [2*DATA_W-1:0]  r_mcand;
   logic [DATA_W-1:0]    r_mplier;
   logic [2*DATA_W-1:0]  w_acc_nxt;

   assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign o_done    = r_act && (r_cnt == LAST);
   assign o_prod    = w_acc_nxt;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_act    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_act    <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= {{DATA_W{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_act) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_act <= 1'b0;
      end
   end

endmodule

// File: rtl/exec_unit_p.sv
// -----------------------------------------------------------------------------
// exec_unit_p
//   NoobsCpu execute unit. Takes one decoded op per cycle over issue_vld /
//   issue_rdy, produces a registered single-cycle writeback, keeps the
//   {Z,N,C,V} flag register, runs MUL through exec_mul_iter and drives a
//   stalling data-memory request for MEM_RD / MEM_WR.
// Ports
//   clk, reset_                 clock, async active-low reset
//   issue_vld / issue_rdy       op handshake (ready only in IDLE)
//   op, src0, src1, imm,        decoded op and operands; operand 1 is imm
//   imm_vld, dst_reg, dst_addr  when imm_vld, else src1
//   reg_wr_en/sel/data          one-cycle writeback pulse
//   flags                       {Z,N,C,V}
//   busy                        multiply in flight
//   d_mem_*                     memory request, held until d_mem_ack
// -----------------------------------------------------------------------------
module exec_unit_p
   import exec_unit_p_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12,
   parameter int RSEL_W = 3
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              issue_vld,
   output logic              issue_rdy,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] src0,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] imm,
   input  logic              imm_vld,
   input  logic [RSEL_W-1:0] dst_reg,
   input  logic [ADDR_W-1:0] dst_addr,
   output logic              reg_wr_en,
   output logic [RSEL_W-1:0] reg_wr_sel,
   output logic [DATA_W-1:0] reg_wr_data,
   output logic [3:0]        flags,
   output logic              busy,
   output logic              d_mem_en,
   output logic              d_mem_rd,
   output logic              d_mem_wr,
   output logic [ADDR_W-1:0] d_mem_addr,
   output logic [DATA_W-1:0] d_mem_data_out,
   input  logic [DATA_W-1:0] d_mem_data_in,
   input  logic              d_mem_ack
);

   state_e              r_state;
   flags_t              r_flags;
   logic                r_wr_en;
   logic [RSEL_W-1:0]   r_wr_sel;
   logic [DATA_W-1:0]   r_wr_data;
   logic [RSEL_W-1:0]   r_pend_sel;   // dst_reg of the in-flight MUL / MEM_RD
   logic                r_mem_en;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_dout;

   op_e                 w_op;
   logic                w_accept;
   logic [DATA_W-1:0]   w_op1;
   logic                w_cin;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_res;
   logic                w_c;
   logic                w_v;
   logic                w_alu_wr;
   logic                w_alu_upd;
   flags_t              w_alu_flags;
   logic                w_mul_done;
   logic [2*DATA_W-1:0] w_mul_prod;
   logic [DATA_W-1:0]   w_mul_lo;

   assign w_op      = op_e'(op);
   assign issue_rdy = (r_state == ST_IDLE);
   assign w_accept  = issue_vld && issue_rdy;
   assign w_op1     = imm_vld ? imm : src1;
   // ADC/SBB chain on the flag register as it stands at issue, which already
   // holds the result of the op accepted one cycle earlier.
   assign w_cin     = ((w_op == OP_ADC) || (w_op == OP_SBB)) ? r_flags.c : 1'b0;

   // ---------------------------------------------------------------- ALU
   always_comb begin
      w_sum     = '0;
      w_res     = '0;
      w_c       = 1'b0;
      w_v       = 1'b0;
      w_alu_wr  = 1'b0;
      w_alu_upd = 1'b0;
      case (w_op)
         OP_ADD, OP_ADC: begin
            w_sum     = {1'b0, src0} + {1'b0, w_op1} + {{DATA_W{1'b0}}, w_cin};
            w_res     = w_sum[DATA_W-1:0];
            w_c       = w_sum[DATA_W];
            w_v       = (src0[DATA_W-1] == w_op1[DATA_W-1]) &&
                        (w_res[DATA_W-1] != src0[DATA_W-1]);
            w_alu_wr  = 1'b1;
            w_alu_upd = 1'b1;
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            // The extra top bit of the (DATA_W+1)-bit difference is the borrow.
            w_sum     = {1'b0, src0} - {1'b0, w_op1} - {{DATA_W{1'b0}}, w_cin};
            w_res     = w_sum[DATA_W-1:0];
            w_c       = w_sum[DATA_W];
            w_v       = (src0[DATA_W-1] != w_op1[DATA_W-1]) &&
                        (w_res[DATA_W-1] != src0[DATA_W-1]);
            w_alu_wr  = (w_op != OP_CMP);
            w_alu_upd = 1'b1;
         end
         OP_OR: begin
            w_res = src0 | w_op1;  w_alu_wr = 1'b1;  w_alu_upd = 1'b1;
         end
         OP_AND: begin
            w_res = src0 & w_op1;  w_alu_wr = 1'b1;  w_alu_upd = 1'b1;
         end
         OP_XOR: begin
            w_res = src0 ^ w_op1;  w_alu_wr = 1'b1;  w_alu_upd = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_alu_flags = flags_t'({(w_res == '0), w_res[DATA_W-1], w_c, w_v});

   // ---------------------------------------------------------- multiplier
   exec_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .reset_  (reset_),
      .i_start (w_accept && (w_op == OP_MUL)),
      .i_a     (src0),
      .i_b     (w_op1),
      .o_done  (w_mul_done),
      .o_prod  (w_mul_prod)
   );

   assign w_mul_lo = w_mul_prod[DATA_W-1:0];

   // ------------------------------------------------------- control FSM
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state    <= ST_IDLE;
         r_flags    <= '0;
         r_wr_en    <= 1'b0;
         r_wr_sel   <= '0;
         r_wr_data  <= '0;
         r_pend_sel <= '0;
         r_mem_en   <= 1'b0;
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_dout <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_pend_sel <= dst_reg;
                  if (w_alu_wr) begin
                     r_wr_en   <= 1'b1;
                     r_wr_sel  <= dst_reg;
                     r_wr_data <= w_res;
                  end
                  if (w_alu_upd) r_flags <= w_alu_flags;
                  if (w_op == OP_MUL) begin
                     r_state <= ST_MUL;
                  end else if (is_mem_op(w_op)) begin
                     r_state    <= ST_MEM;
                     r_mem_en   <= 1'b1;
                     r_mem_rd   <= (w_op == OP_MEM_RD);
                     r_mem_wr   <= (w_op == OP_MEM_WR);
                     r_mem_addr <= dst_addr;
                     r_mem_dout <= src0;
                  end
               end
            end
            ST_MUL: begin
               if (w_mul_done) begin
                  r_wr_en   <= 1'b1;
                  r_wr_sel  <= r_pend_sel;
                  r_wr_data <= w_mul_lo;
                  r_flags   <= flags_t'({(w_mul_lo == '0), w_mul_lo[DATA_W-1],
                                         (w_mul_prod[2*DATA_W-1:DATA_W] != '0), 1'b0});
                  r_state   <= ST_IDLE;
               end
            end
            ST_MEM: begin
               if (d_mem_ack) begin
                  r_mem_en <= 1'b0;
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  r_state  <= ST_IDLE;
                  if (r_mem_rd) begin
                     r_wr_en   <= 1'b1;
                     r_wr_sel  <= r_pend_sel;
                     r_wr_data <= d_mem_data_in;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy           = (r_state == ST_MUL);
   assign flags          = r_flags;
   assign reg_wr_en      = r_wr_en;
   assign reg_wr_sel     = r_wr_sel;
   assign reg_wr_data    = r_wr_data;
   assign d_mem_en       = r_mem_en;
   assign d_mem_rd       = r_mem_rd;
   assign d_mem_wr       = r_mem_wr;
   assign d_mem_addr     = r_mem_addr;
   assign d_mem_data_out = r_mem_dout;

endmodule

// File: tb/tb_exec_unit_p.sv
// -----------------------------------------------------------------------------
// tb_exec_unit_p
//   Scoreboarded bench for exec_unit_p (DATA_W=8). The driver computes each
//   op's effect with plain integer arithmetic and queues the expected
//   writeback (with its cycle); a monitor pops and compares on reg_wr_en.
//   A memory responder serves requests with a bench-chosen latency and
//   checks the request contents.
// -----------------------------------------------------------------------------
module tb_exec_unit_p;

   logic        clk;
   logic        reset_;
   logic        issue_vld;
   logic        issue_rdy;
   logic [3:0]  op;
   logic [7:0]  src0, src1, imm;
   logic        imm_vld;
   logic [2:0]  dst_reg;
   logic [11:0] dst_addr;
   logic        reg_wr_en;
   logic [2:0]  reg_wr_sel;
   logic [7:0]  reg_wr_data;
   logic [3:0]  flags;
   logic        busy;
   logic        d_mem_en, d_mem_rd, d_mem_wr;
   logic [11:0] d_mem_addr;
   logic [7:0]  d_mem_data_out;
   logic [7:0]  d_mem_data_in;
   logic        d_mem_ack;

   exec_unit_p #(.DATA_W(8), .ADDR_W(12), .RSEL_W(3)) dut (
      .clk(clk), .reset_(reset_), .issue_vld(issue_vld), .issue_rdy(issue_rdy),
      .op(op), .src0(src0), .src1(src1), .imm(imm), .imm_vld(imm_vld),
      .dst_reg(dst_reg), .dst_addr(dst_addr), .reg_wr_en(reg_wr_en),
      .reg_wr_sel(reg_wr_sel), .reg_wr_data(reg_wr_data), .flags(flags),
      .busy(busy), .d_mem_en(d_mem_en), .d_mem_rd(d_mem_rd), .d_mem_wr(d_mem_wr),
      .d_mem_addr(d_mem_addr), .d_mem_data_out(d_mem_data_out),
      .d_mem_data_in(d_mem_data_in), .d_mem_ack(d_mem_ack)
   );

   typedef struct { int sel; int data; logic [3:0] fl; int cyc; } wb_t;
   typedef struct { bit rd; int addr; int sd; int wt; int ld; } mreq_t;

   wb_t        exp_q[$];
   mreq_t      mem_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_len = 0;
   logic [3:0] mfl = 4'h0;   // reference {Z,N,C,V}

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outs(input string nm);
      chk(nm, {issue_rdy, busy, reg_wr_en, reg_wr_sel, reg_wr_data, flags, d_mem_en,
               d_mem_rd, d_mem_wr, d_mem_addr, d_mem_data_out}, 64'h1 << 40);
   endtask

   function automatic int sgn(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   // Architectural effect of one non-memory op on 8-bit operands.
   function automatic void model(input int o, input int a, input int b, input logic [3:0] fin,
                                 output bit wr, output int res, output logic [3:0] fout);
      int s, ss, ci;
      wr = 1'b0; res = 0; fout = fin;
      ci = fin[1] ? 1 : 0;
      case (o)
         1, 12: begin
            if (o == 1) ci = 0;
            s = a + b + ci;  ss = sgn(a) + sgn(b) + ci;  res = s % 256;
            fout = {res == 0, res > 127, s > 255, (ss > 127) || (ss < -128)};
            wr = 1'b1;
         end
         2, 13, 14: begin
            if (o != 13) ci = 0;
            s = a - b - ci;  ss = sgn(a) - sgn(b) - ci;  res = (s + 256) % 256;
            fout = {res == 0, res > 127, s < 0, (ss > 127) || (ss < -128)};
            wr = (o != 14);
         end
         3, 4, 5: begin
            res = (o == 3) ? (a | b) : (o == 4) ? (a & b) : (a ^ b);
            fout = {res == 0, res > 127, 1'b0, 1'b0};
            wr = 1'b1;
         end
         15: begin
            s = a * b;  res = s % 256;
            fout = {res == 0, res > 127, s > 255, 1'b0};
            wr = 1'b1;
         end
         default: ;
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input int o, input int s0, input int s1, input int im, input int iv,
                        input int dsel, input int daddr, input int wt, input int ld);
      bit got;
      int a_cyc, b, res;
      bit wr;
      logic [3:0] nf;
      op = o[3:0]; src0 = s0[7:0]; src1 = s1[7:0]; imm = im[7:0];
      imm_vld = (iv != 0); dst_reg = dsel[2:0]; dst_addr = daddr[11:0];
      issue_vld = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
         @(negedge clk);
         if (issue_rdy) got = 1'b1;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL issue_timeout: op %0d issue_rdy=%0b want 1", o, issue_rdy);
         issue_vld = 1'b0;
         return;
      end
      @(posedge clk); #1;
      issue_vld = 1'b0;
      a_cyc = cyc;
      b = (iv != 0) ? im : s1;
      if (o == 6) begin
         mem_q.push_back('{1'b1, daddr, s0, wt, ld});
         exp_q.push_back('{dsel, ld, mfl, a_cyc + wt + 1});
      end else if (o == 7) begin
         mem_q.push_back('{1'b0, daddr, s0, wt, ld});
      end else begin
         model(o, s0, b, mfl, wr, res, nf);
         mfl = nf;
         if (wr) exp_q.push_back('{dsel, res, nf, (o == 15) ? a_cyc + 8 : a_cyc});
      end
   endtask

   // Writeback monitor.
   always @(negedge clk) begin : mon
      wb_t e;
      if (reset_) begin
         if (reg_wr_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL wb_unexpected: got sel=%0d data=%0h at cyc %0d want no writeback",
                        reg_wr_sel, reg_wr_data, cyc);
            end else begin
               e = exp_q.pop_front();
               if (reg_wr_sel !== e.sel[2:0] || reg_wr_data !== e.data[7:0] ||
                   flags !== e.fl || cyc != e.cyc) begin
                  n_err++;
                  $display("FAIL wb: got sel=%0d data=%0h fl=%b cyc=%0d want sel=%0d data=%0h fl=%b cyc=%0d",
                           reg_wr_sel, reg_wr_data, flags, cyc, e.sel, e.data, e.fl, e.cyc);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL wb_missing: got none by cyc %0d want sel=%0d data=%0h at cyc %0d",
                     cyc, e.sel, e.data, e.cyc);
         end
      end
   end

   // Memory responder; also throws stray acks while no request is open.
   always @(negedge clk) begin : mem_resp
      static bit    act = 1'b0;
      static int    run = 0;
      static mreq_t cur = '{1'b1, 0, 0, 0, 0};
      d_mem_ack = 1'b0;
      if (!reset_) begin
         act = 1'b0; run = 0;
      end else if (d_mem_en) begin
         if (!act) begin
            n_vec++;
            if (mem_q.size() == 0) begin
               n_err++;
               $display("FAIL mem_unexpected: got request addr=%0h want none", d_mem_addr);
               cur = '{1'b1, 0, 0, 0, 0};
            end else begin
               cur = mem_q.pop_front();
               if ({d_mem_rd, d_mem_wr} !== {cur.rd, ~cur.rd} || d_mem_addr !== cur.addr[11:0] ||
                   d_mem_data_out !== cur.sd[7:0]) begin
                  n_err++;
                  $display("FAIL mem_req: got rd=%0b wr=%0b addr=%0h dout=%0h want rd=%0b addr=%0h dout=%0h",
                           d_mem_rd, d_mem_wr, d_mem_addr, d_mem_data_out, cur.rd, cur.addr, cur.sd);
               end
            end
            act = 1'b1; run = 0;
         end
         run++;
         if (run > cur.wt) begin
            d_mem_ack = 1'b1;
            d_mem_data_in = cur.ld[7:0];
            act = 1'b0;
            last_len = run;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         d_mem_ack = 1'b1;
         d_mem_data_in = 8'($urandom_range(0, 255));
      end
   end

   function automatic int pick();
      case ($urandom_range(0, 7))
         0: return 0;
         1: return 255;
         2: return 128;
         3: return 127;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic do_reset_mid(input string nm);
      @(negedge clk); #2;
      reset_ = 1'b0;
      #1 chk_reset_outs(nm);
      exp_q.delete(); mem_q.delete(); mfl = 4'h0;
      @(negedge clk); #2;
      reset_ = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      reset_ = 1'b0; issue_vld = 1'b0; op = '0; src0 = '0; src1 = '0; imm = '0;
      imm_vld = 1'b0; dst_reg = '0; dst_addr = '0; d_mem_data_in = '0; d_mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset_state");
      reset_ = 1'b1;
      @(posedge clk); #1;

      // ADD with carry out, then ADC consuming it back-to-back.
      issue(1, 'hF0, 'h20, 0, 0, 1, 0, 0, 0);
      issue(12, 'h01, 'h01, 0, 0, 2, 0, 0, 0);
      // Signed overflow on SUB; CMP equal with immediate.
      issue(2, 'h80, 'h01, 0, 0, 3, 0, 0, 0);
      issue(14, 'h05, 'hEE, 'h05, 1, 4, 0, 0, 0);
      @(negedge clk);
      chk("cmp_flags", flags, 4'b1000);
      @(posedge clk); #1;

      // MUL: 8 busy cycles with issue_rdy low.
      issue(15, 'h10, 'h20, 0, 0, 5, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mul_busy", {busy, issue_rdy}, 2'b10);
      end
      @(negedge clk);
      chk("mul_done_rdy", {busy, issue_rdy}, 2'b01);
      @(posedge clk); #1;

      // MEM_RD with 3 wait cycles.
      issue(6, 'h33, 0, 0, 0, 6, 'h123, 3, 'h5A);
      repeat (6) @(negedge clk);
      chk("mem_req_len", last_len, 4);
      @(posedge clk); #1;

      // Zero-wait store.
      issue(7, 'hC3, 0, 0, 0, 0, 'hABC, 0, 0);

      // Reset in the middle of a MUL, then of a MEM_RD.
      issue(15, 'h7F, 'h03, 0, 0, 1, 0, 0, 0);
      repeat (2) @(negedge clk);
      do_reset_mid("reset_mid_mul");
      issue(1, 'h12, 'h34, 0, 0, 2, 0, 0, 0);
      issue(6, 'h00, 0, 0, 0, 3, 'h456, 10, 'h99);
      @(negedge clk);
      do_reset_mid("reset_mid_mem");
      issue(1, 'hFF, 'h01, 0, 0, 4, 0, 0, 0);
      issue(7, 'h11, 0, 0, 0, 0, 'h001, 1, 0);

      // Randomized stream, mostly back-to-back.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
         issue(int'($urandom_range(0, 15)), pick(), pick(), pick(), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
               int'($urandom_range(0, 4)), pick());
      end

      for (int w = 0; w < 100 && (exp_q.size() > 0 || !issue_rdy); w++) @(negedge clk);
      chk("drain_pending", exp_q.size(), 0);
      chk("drain_idle", issue_rdy, 1);
      @(negedge clk);
      chk("final_flags", flags, mfl);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
